// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: control codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational add/subtract ALU producing result and {N,Z,C,V}.
module alu
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [5:0]   ctrl,
  output logic [n-1:0] result,
  output logic [3:0]   flags
);

  logic         is_sub;
  logic [n-1:0] b_eff;
  logic [n:0]   sum;

  // Subtraction is a + ~b + 1, so C is carry-out (set when no borrow).
  always_comb begin
    is_sub = (ctrl == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, is_sub};
    result = sum[n-1:0];
    flags  = '0;
    flags[FLAG_N] = sum[n-1];
    flags[FLAG_Z] = (sum[n-1:0] == '0);
    flags[FLAG_C] = sum[n];
    flags[FLAG_V] = (a[n-1] == b_eff[n-1]) && (sum[n-1] != a[n-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ valid/ready requesters,
// one operation at a time: accept, execute, respond.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int n    = 32,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  input  logic [NREQ*6-1:0] req_ctrl,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [n-1:0]      rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Returns {found, index} of the first valid requester at or above ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] jj;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && valid[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] src_q;
  logic [n-1:0]  a_q, b_q;
  logic [5:0]    ctrl_q;
  logic [n-1:0]  result_q;
  logic [3:0]    flags_q;
  logic          err_q;

  logic [IW:0]   pick;
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [n-1:0]  alu_result;
  logic [3:0]    alu_flags;
  logic          ctrl_ok;
  logic [IW-1:0] ptr_next;

  alu #(.n(n)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .ctrl   (ctrl_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    pick        = rr_pick(req_valid, rr_ptr_q);
    grant_found = pick[IW];
    grant_idx   = pick[IW-1:0];
    ctrl_ok     = (ctrl_q == ALU_ADD) || (ctrl_q == ALU_SUB);
    ptr_next    = (src_q == IW'(NREQ - 1)) ? '0 : src_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[src_q] = 1'b1;
        if (rsp_ready[src_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            a_q    <= req_a[int'(grant_idx)*n +: n];
            b_q    <= req_b[int'(grant_idx)*n +: n];
            ctrl_q <= req_ctrl[int'(grant_idx)*6 +: 6];
            src_q  <= grant_idx;
          end
        end
        // Flags from the ALU are meaningless for codes other than ADD/SUB.
        EXEC: begin
          result_q <= ctrl_ok ? alu_result : '0;
          flags_q  <= ctrl_ok ? alu_flags : 4'b0000;
          err_q    <= !ctrl_ok;
        end
        RESP: begin
          if (rsp_ready[src_q]) rr_ptr_q <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven self-checking bench for alu_arbiter (n=32, NREQ=2).
module tb_alu_arbiter;

  localparam int N = 32;
  localparam int R = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R*6-1:0] req_ctrl;
  logic [R-1:0]   rsp_valid;
  logic [R-1:0]   rsp_ready;
  logic [N-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.n(N), .NREQ(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic [3:0]  flag_mask;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] ctrl);
    req_a[idx*N +: N]    = a;
    req_b[idx*N +: N]    = b;
    req_ctrl[idx*6 +: 6] = ctrl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [R-1:0] exp_oh;
    int grant_seq[$];
    int rsp_cyc[$];
    logic [31:0] rsp_val[$];

    vecs[0] = '{0, 32'd5,          32'd3, 6'b000000, 32'd8,          4'b0000, 4'b1111, 1'b0};
    vecs[1] = '{1, 32'd7,          32'd7, 6'b000001, 32'd0,          4'b0100, 4'b1101, 1'b0};
    vecs[2] = '{0, 32'h7FFF_FFFF,  32'd1, 6'b000000, 32'h8000_0000,  4'b1001, 4'b1111, 1'b0};
    vecs[3] = '{1, 32'd9,          32'd4, 6'b000010, 32'd0,          4'b0000, 4'b1111, 1'b1};
    vecs[4] = '{0, 32'd1,          32'd1, 6'b000000, 32'd2,          4'b0000, 4'b1111, 1'b0};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1, 6'b000000, 32'd0,          4'b0110, 4'b1111, 1'b0};
    vecs[6] = '{0, 32'd3,          32'd5, 6'b000001, 32'hFFFF_FFFE,  4'b1000, 4'b1101, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    repeat (2) @(negedge clk);

    // Reset values
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_result", 64'(rsp_result), 64'd0);
    chk("reset_flags", 64'(rsp_flags), 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-requester transactions from the vector table
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      exp_oh = '0;
      exp_oh[vecs[v].idx] = 1'b1;
      set_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].ctrl);
      req_valid = exp_oh;
      #1;
      chk($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(exp_oh));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk($sformatf("v%0d_exec_busy", v), 64'(busy), 64'd1);
      chk($sformatf("v%0d_exec_rsp_valid", v), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_exec_req_ready", v), 64'(req_ready), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", v), 64'(rsp_valid), 64'(exp_oh));
      chk($sformatf("v%0d_result", v), 64'(rsp_result), 64'(vecs[v].exp_result));
      chk($sformatf("v%0d_flags", v), 64'(rsp_flags & vecs[v].flag_mask),
          64'(vecs[v].exp_flags));
      chk($sformatf("v%0d_err", v), 64'(rsp_err), 64'(vecs[v].exp_err));
      rsp_ready = exp_oh;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_idle_rsp_valid", v), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_hold_result", v), 64'(rsp_result), 64'(vecs[v].exp_result));
    end

    // Reset during EXEC: RR pointer is 1 here (last accepted was requester 0)
    @(negedge clk);
    set_op(1, 32'd40, 32'd2, 6'b000000);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstexec_busy", 64'(busy), 64'd0);
    chk("rstexec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstexec_result", 64'(rsp_result), 64'd0);
    chk("rstexec_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rstexec_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("rstexec_ptr0_grant", 64'(req_ready), 64'b01);
    do_reset();

    // Both requesters continuously valid, responses accepted immediately
    set_op(0, 32'd10, 32'd1, 6'b000000);
    set_op(1, 32'd20, 32'd2, 6'b000000);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready == 2'b11) chk("fair_not_both", 64'(req_ready), 64'b00);
      if (req_ready == 2'b01) grant_seq.push_back(0);
      if (req_ready == 2'b10) grant_seq.push_back(1);
      if (rsp_valid != 2'b00) begin
        rsp_cyc.push_back(c);
        rsp_val.push_back(rsp_result);
      end
      @(negedge clk);
    end
    chk("fair_grant_count", 64'(grant_seq.size()), 64'd4);
    chk("fair_rsp_count", 64'(rsp_cyc.size()), 64'd4);
    for (int i = 0; i < grant_seq.size(); i++)
      chk($sformatf("fair_grant%0d", i), 64'(grant_seq[i]), 64'(i % 2));
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk($sformatf("fair_spacing%0d", i), 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd3);
    for (int i = 0; i < rsp_val.size(); i++)
      chk($sformatf("fair_result%0d", i), 64'(rsp_val[i]), (i % 2 == 0) ? 64'd11 : 64'd22);
    do_reset();

    // Response back-pressure with requester 1 pending
    set_op(0, 32'd100, 32'd23, 6'b000000);
    set_op(1, 32'd20, 32'd2, 6'b000000);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    chk("bp_grant0", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      rsp_ready = (c % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      chk($sformatf("bp_rsp_valid%0d", c), 64'(rsp_valid), 64'b01);
      chk($sformatf("bp_result%0d", c), 64'(rsp_result), 64'd123);
      chk($sformatf("bp_flags%0d", c), 64'(rsp_flags), 64'd0);
      chk($sformatf("bp_err%0d", c), 64'(rsp_err), 64'd0);
      chk($sformatf("bp_busy%0d", c), 64'(busy), 64'd1);
      chk($sformatf("bp_req_ready%0d", c), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("bp_next_grant1", 64'(req_ready), 64'b10);
    chk("bp_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp_hold_result", 64'(rsp_result), 64'd123);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_rsp1_valid", 64'(rsp_valid), 64'b10);
    chk("bp_rsp1_result", 64'(rsp_result), 64'd22);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("bp_final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
